// File: rtl/lcd_seq_ctrl.sv
// Serial LCD link sequencer: panel reset, power-up command list with delays,
// then an endless loop of window programming and RGB565 pixel streaming.
module lcd_seq_ctrl #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int RST_CYCLES = 400000,
  parameter int MS_CYCLES  = 40000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_dc,
  input  logic        tx_ready,
  output logic        lcd_rst_n,
  output logic [8:0]  hpos,
  output logic [7:0]  vpos,
  input  logic [15:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        init_done
);

  localparam int MAX_CNT = (RST_CYCLES > 150 * MS_CYCLES) ? RST_CYCLES : 150 * MS_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [15:0]   W_LAST    = 16'(WIDTH - 1);
  localparam logic [15:0]   H_LAST    = 16'(HEIGHT - 1);
  localparam logic [8:0]    HPOS_LAST = 9'(WIDTH - 1);
  localparam logic [7:0]    VPOS_LAST = 8'(HEIGHT - 1);
  localparam logic [3:0]    INIT_LAST = 4'd6;
  localparam logic [3:0]    WIN_LAST  = 4'd10;

  typedef enum logic [2:0] {
    RST_LOW, RST_WAIT, INIT, DELAY, WIN, FETCH, PIX_HI, PIX_LO
  } state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
    logic [7:0] ms;
  } init_ent_t;

  // ms = 0 means the next entry follows without a delay
  function automatic init_ent_t init_rom(input logic [3:0] i);
    init_ent_t e;
    e = '0;
    case (i)
      4'd0:    e = '{dc: 1'b0, data: 8'h01, ms: 8'd150};
      4'd1:    e = '{dc: 1'b0, data: 8'h11, ms: 8'd120};
      4'd2:    e = '{dc: 1'b0, data: 8'h3A, ms: 8'd0};
      4'd3:    e = '{dc: 1'b1, data: 8'h55, ms: 8'd0};
      4'd4:    e = '{dc: 1'b0, data: 8'h36, ms: 8'd0};
      4'd5:    e = '{dc: 1'b1, data: 8'h60, ms: 8'd0};
      4'd6:    e = '{dc: 1'b0, data: 8'h29, ms: 8'd20};
      default: e = '0;
    endcase
    return e;
  endfunction

  // Returns {dc, data}
  function automatic logic [8:0] win_rom(input logic [3:0] i);
    logic [8:0] b;
    b = '0;
    case (i)
      4'd0:    b = {1'b0, 8'h2A};
      4'd1:    b = {1'b1, 8'h00};
      4'd2:    b = {1'b1, 8'h00};
      4'd3:    b = {1'b1, W_LAST[15:8]};
      4'd4:    b = {1'b1, W_LAST[7:0]};
      4'd5:    b = {1'b0, 8'h2B};
      4'd6:    b = {1'b1, 8'h00};
      4'd7:    b = {1'b1, 8'h00};
      4'd8:    b = {1'b1, H_LAST[15:8]};
      4'd9:    b = {1'b1, H_LAST[7:0]};
      4'd10:   b = {1'b0, 8'h2C};
      default: b = '0;
    endcase
    return b;
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] dly_last;
  logic [3:0]    idx;
  logic [7:0]    pix_lo;

  init_ent_t  cur_ent, nxt_ent;
  logic [8:0] win_first, win_nxt;

  always_comb begin
    cur_ent   = init_rom(idx);
    nxt_ent   = init_rom(idx + 4'd1);
    win_first = win_rom(4'd0);
    win_nxt   = win_rom(idx + 4'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RST_LOW;
      cnt       <= '0;
      dly_last  <= '0;
      idx       <= '0;
      pix_lo    <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_dc     <= 1'b0;
      lcd_rst_n <= 1'b0;
      hpos      <= '0;
      vpos      <= '0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      hsync <= 1'b0;
      vsync <= 1'b0;
      case (state)
        RST_LOW: begin
          if (cnt == RST_LAST) begin
            cnt       <= '0;
            lcd_rst_n <= 1'b1;
            state     <= RST_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RST_WAIT: begin
          if (cnt == RST_LAST) begin
            cnt      <= '0;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_dc    <= cur_ent.dc;
            tx_data  <= cur_ent.data;
            state    <= INIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // INIT and DELAY share the "advance to next entry" path
        INIT, DELAY: begin
          if (state == INIT && tx_ready && cur_ent.ms != '0) begin
            tx_valid <= 1'b0;
            cnt      <= '0;
            dly_last <= CW'(int'(cur_ent.ms) * MS_CYCLES - 1);
            state    <= DELAY;
          end else if ((state == INIT && tx_ready) || (state == DELAY && cnt == dly_last)) begin
            tx_valid <= 1'b1;
            if (idx == INIT_LAST) begin
              init_done        <= 1'b1;
              idx              <= '0;
              {tx_dc, tx_data} <= win_first;
              state            <= WIN;
            end else begin
              idx     <= idx + 4'd1;
              tx_dc   <= nxt_ent.dc;
              tx_data <= nxt_ent.data;
              state   <= INIT;
            end
          end else if (state == DELAY) begin
            cnt <= cnt + CW'(1);
          end
        end
        WIN: begin
          if (tx_ready) begin
            if (idx == WIN_LAST) begin
              idx      <= '0;
              tx_valid <= 1'b0;
              state    <= FETCH;
            end else begin
              idx              <= idx + 4'd1;
              {tx_dc, tx_data} <= win_nxt;
            end
          end
        end
        FETCH: begin
          pix_lo   <= rgb[7:0];
          tx_valid <= 1'b1;
          tx_dc    <= 1'b1;
          tx_data  <= rgb[15:8];
          state    <= PIX_HI;
        end
        PIX_HI: begin
          if (tx_ready) begin
            tx_data <= pix_lo;
            state   <= PIX_LO;
          end
        end
        PIX_LO: begin
          if (tx_ready) begin
            if (hpos != HPOS_LAST) begin
              hpos     <= hpos + 9'd1;
              tx_valid <= 1'b0;
              state    <= FETCH;
            end else begin
              hpos  <= '0;
              hsync <= 1'b1;
              if (vpos != VPOS_LAST) begin
                vpos     <= vpos + 8'd1;
                tx_valid <= 1'b0;
                state    <= FETCH;
              end else begin
                vpos             <= '0;
                vsync            <= 1'b1;
                idx              <= '0;
                {tx_dc, tx_data} <= win_first;
                state            <= WIN;
              end
            end
          end
        end
        default: state <= RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Self-checking bench for lcd_seq_ctrl: expected byte table with inter-byte
// gaps, plus directed backpressure, random-ready and mid-operation reset runs.
module tb_lcd_seq_ctrl;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int RC = 3;
  localparam int MS = 2;
  localparam int NB = 62;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_ready = 1'b0;
  logic        tx_valid, tx_dc, lcd_rst_n, hsync, vsync, init_done;
  logic [7:0]  tx_data;
  logic [8:0]  hpos;
  logic [7:0]  vpos;
  logic [15:0] rgb;

  lcd_seq_ctrl #(.WIDTH(W), .HEIGHT(H), .RST_CYCLES(RC), .MS_CYCLES(MS)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_ready(tx_ready), .lcd_rst_n(lcd_rst_n), .hpos(hpos), .vpos(vpos), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .init_done(init_done)
  );

  always #5 clk = ~clk;
  assign rgb = {7'b0, vpos[0], hpos[7:0]};

  typedef struct { int gap; logic dc; logic [7:0] data; } vec_t;
  typedef struct { logic dc; logic [7:0] data; int at; } acc_t;

  vec_t tbl[NB];
  acc_t acc[$];
  int   hs_at[$];
  int   vs_at[$];
  int   cyc = 0;
  int   init_rise = -1;
  int   hold_err = 0;
  logic pend = 1'b0;
  logic [8:0] pend_v = '0;
  int unsigned total = 0;
  int unsigned bad = 0;

  always @(posedge clk) begin
    if (!reset) cyc = 0;
    else cyc++;
  end

  // Bytes are logged at the negedge before the posedge that accepts them
  always @(negedge clk) begin
    if (!reset) begin
      acc.delete(); hs_at.delete(); vs_at.delete();
      init_rise = -1; pend = 1'b0; hold_err = 0;
    end else begin
      if (pend && !(tx_valid && {tx_dc, tx_data} == pend_v)) hold_err++;
      pend   = tx_valid && !tx_ready;
      pend_v = {tx_dc, tx_data};
      if (hsync) hs_at.push_back(acc.size());
      if (vsync) vs_at.push_back(acc.size());
      if (tx_valid && tx_ready) acc.push_back('{dc: tx_dc, data: tx_data, at: cyc + 1});
      if (init_done && init_rise < 0) init_rise = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [30:0] outs();
    return {tx_valid, tx_data, tx_dc, lcd_rst_n, hpos, vpos, hsync, vsync, init_done};
  endfunction

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk({tag, "_outs"}, 32'(outs()), 32'd0);
  endtask

  task automatic release_and_check(input string tag);
    int lo = 0;
    int hi = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_valid) break;
      if (!lcd_rst_n) lo++;
      else hi++;
    end
    chk({tag, "_rst_low_cycles"}, lo, 3);
    chk({tag, "_wait_cycles"}, hi, 3);
    chk({tag, "_first_byte"}, {tx_valid, tx_dc, tx_data}, {1'b1, 1'b0, 8'h01});
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k = 0;
    while (acc.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk({name, "_reached"}, 32'(acc.size() >= n), 32'd1);
  endtask

  initial begin
    vec_t init_v[7];
    logic [8:0] win_v[11];
    int hs_exp[4];
    int vs_exp[2];
    int n = 0;

    init_v = '{'{0, 1'b0, 8'h01}, '{301, 1'b0, 8'h11}, '{241, 1'b0, 8'h3A},
               '{1, 1'b1, 8'h55}, '{1, 1'b0, 8'h36}, '{1, 1'b1, 8'h60}, '{1, 1'b0, 8'h29}};
    win_v  = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103, 9'h02B,
               9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
    hs_exp = '{26, 34, 53, 61};
    vs_exp = '{34, 61};
    for (int i = 0; i < 7; i++) begin tbl[n] = init_v[i]; n++; end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 11; i++) begin
        tbl[n] = '{(i == 0) ? ((f == 0) ? 41 : 1) : 1, win_v[i][8], win_v[i][7:0]};
        n++;
      end
      for (int v = 0; v < H; v++)
        for (int h = 0; h < W; h++) begin
          tbl[n] = '{2, 1'b1, 8'(v)}; n++;
          tbl[n] = '{1, 1'b1, 8'(h)}; n++;
        end
    end
    tbl[n] = '{1, 1'b0, 8'h2A};

    #1 reset = 1'b0;

    // Two frames with tx_ready tied high
    tx_ready = 1'b1;
    apply_reset("rst0");
    release_and_check("boot");
    wait_bytes(NB, 3000, "frames");
    if (acc.size() > 0) chk("first_accept_cycle", acc[0].at, 7);
    for (int k = 0; k < NB && k < acc.size(); k++) begin
      chk($sformatf("byte%0d", k), {acc[k].dc, acc[k].data}, {tbl[k].dc, tbl[k].data});
      if (k > 0) chk($sformatf("gap%0d", k), acc[k].at - acc[k-1].at, tbl[k].gap);
    end
    if (acc.size() > 6) chk("init_done_delay", init_rise - acc[6].at, 40);
    chk("hsync_count", hs_at.size(), 4);
    chk("vsync_count", vs_at.size(), 2);
    for (int i = 0; i < 4 && i < hs_at.size(); i++) chk($sformatf("hsync_pos%0d", i), hs_at[i], hs_exp[i]);
    for (int i = 0; i < 2 && i < vs_at.size(); i++) chk($sformatf("vsync_pos%0d", i), vs_at[i], vs_exp[i]);

    // Backpressure on the HI byte of pixel (3,1)
    apply_reset("rst1");
    release_and_check("boot_bp");
    wait_bytes(32, 3000, "bp_reach");
    #1 tx_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {tx_valid, tx_dc, tx_data}, {1'b1, 1'b1, 8'h01});
    end
    chk("bp_no_xfer", acc.size(), 32);
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_one_xfer", acc.size(), 33);
    if (acc.size() > 32) chk("bp_hi_byte", {acc[32].dc, acc[32].data}, 9'h101);
    chk("bp_lo_pending", {tx_valid, tx_dc, tx_data}, {1'b1, 1'b1, 8'h03});
    chk("bp_hold_rule", hold_err, 0);
    tx_ready = 1'b1;

    // Random tx_ready: byte order must match the tied-high run
    apply_reset("rst2");
    release_and_check("boot_rand");
    begin
      int k = 0;
      while (acc.size() < NB && k < 20000) begin
        @(posedge clk);
        #1 tx_ready = 1'($urandom_range(0, 1));
        k++;
      end
      chk("rand_reached", 32'(acc.size() >= NB), 32'd1);
    end
    for (int k = 0; k < NB && k < acc.size(); k++)
      chk($sformatf("rand_byte%0d", k), {acc[k].dc, acc[k].data}, {tbl[k].dc, tbl[k].data});
    chk("rand_hold_rule", hold_err, 0);

    // Reset in the middle of the 150 ms delay, then during PIX_LO
    tx_ready = 1'b1;
    apply_reset("rst3");
    release_and_check("boot_mr");
    wait_bytes(1, 100, "mr_first");
    repeat (50) @(posedge clk);
    chk("mr_in_delay", {lcd_rst_n, tx_valid, 8'(acc.size())}, {1'b1, 1'b0, 8'd1});
    #3 reset = 1'b0;
    #1 chk("mr_delay_async", 32'(outs()), 32'd0);
    release_and_check("restart1");
    wait_bytes(19, 3000, "mr_reach_lo");
    #3 chk("mr_in_lo", {tx_valid, tx_dc, init_done}, 3'b111);
    reset = 1'b0;
    #1 chk("mr_lo_async", 32'(outs()), 32'd0);
    release_and_check("restart2");
    wait_bytes(1, 100, "mr_restart_first");
    if (acc.size() > 0) chk("mr_restart_byte", {acc[0].dc, acc[0].data, 8'(acc[0].at)}, {1'b0, 8'h01, 8'd7});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
